// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package muldiv_pkg;

    localparam logic [1:0] OP_DIVU  = 2'b00;
    localparam logic [1:0] OP_DIV   = 2'b01;
    localparam logic [1:0] OP_MULTU = 2'b10;
    localparam logic [1:0] OP_MULT  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/muldiv_if.sv
// EX-stage request/result bundle for muldiv_unit (master = EX, slave = unit).
// Latency: n/a (wires only).
// Backpressure: EX holds start_i high for the whole operation; dropping it aborts.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic                 start_i;
    logic [1:0]           op_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic                 annul_i;
    logic                 busy_o;
    logic                 ready_o;
    logic                 dz_o;
    logic [2*WIDTH-1:0]   result_o;

    modport master (
        output start_i, op_i, opdata1_i, opdata2_i, annul_i,
        input  busy_o, ready_o, dz_o, result_o
    );

    modport slave (
        input  start_i, op_i, opdata1_i, opdata2_i, annul_i,
        output busy_o, ready_o, dz_o, result_o
    );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: restoring shift-subtract divide or shift-add multiply (MULDIV_MUL_EN).
// Latency: combinational.
// Backpressure: none; the caller decides when to register the result.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] opnd_i,
    input  logic             is_mul_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    logic [WIDTH:0] shl;
    logic [WIDTH:0] diff;
`ifdef MULDIV_MUL_EN
    logic [WIDTH:0] sum;
`else
    logic           unused_is_mul;
    assign unused_is_mul = is_mul_i;
`endif

    // Next partial {hi, lo}; hi stays below the divisor so the trial fits WIDTH+1 bits.
    always_comb begin
        shl  = {hi_i, lo_i[WIDTH-1]};
        diff = shl - {1'b0, opnd_i};
        hi_o = shl[WIDTH-1:0];
        lo_o = {lo_i[WIDTH-2:0], 1'b0};
        if (!diff[WIDTH]) begin
            hi_o    = diff[WIDTH-1:0];
            lo_o[0] = 1'b1;
        end
`ifdef MULDIV_MUL_EN
        sum = lo_i[0] ? ({1'b0, hi_i} + {1'b0, opnd_i}) : {1'b0, hi_i};
        if (is_mul_i) begin
            hi_o = sum[WIDTH:1];
            lo_o = {sum[0], lo_i[WIDTH-1:1]};
        end
`endif
    end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned divide, plus multiply when MULDIV_MUL_EN is defined.
// Latency: WIDTH+1 edges from the start edge to ready_o; divide-by-zero (or multiply when disabled) 1 edge.
// Backpressure: start_i must stay high; dropping it or raising annul_i aborts or releases the result.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic    clk,
    input  logic    rst,
    muldiv_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
    logic                 is_mul_q, is_mul_d, qneg_q, qneg_d, rneg_q, rneg_d;
    logic                 busy_q, busy_d, ready_q, ready_d, dz_q, dz_d;
    logic [2*WIDTH-1:0]   result_q, result_d, fin;
    logic [WIDTH-1:0]     step_hi, step_lo, mag1, mag2;
    logic                 sgn1, sgn2;

    // Signed operands become unsigned magnitudes; MIN maps to 2^(WIDTH-1).
    assign sgn1 = bus.op_i[0] & bus.opdata1_i[WIDTH-1];
    assign sgn2 = bus.op_i[0] & bus.opdata2_i[WIDTH-1];
    assign mag1 = sgn1 ? -bus.opdata1_i : bus.opdata1_i;
    assign mag2 = sgn2 ? -bus.opdata2_i : bus.opdata2_i;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .hi_i     (hi_q),
        .lo_i     (lo_q),
        .opnd_i   (opnd_q),
        .is_mul_i (is_mul_q),
        .hi_o     (step_hi),
        .lo_o     (step_lo)
    );

    // Sign-correct the final iteration's output.
    always_comb begin
        fin = {rneg_q ? -step_hi : step_hi, qneg_q ? -step_lo : step_lo};
`ifdef MULDIV_MUL_EN
        if (is_mul_q) begin
            fin = qneg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
        end
`endif
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        is_mul_d = is_mul_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        busy_d   = busy_q;
        ready_d  = ready_q;
        dz_d     = dz_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (bus.start_i && !bus.annul_i) begin
                    is_mul_d = bus.op_i[1];
                    qneg_d   = sgn1 ^ sgn2;
                    rneg_d   = sgn1;
                    cnt_d    = '0;
                    hi_d     = '0;
                    if (bus.op_i[1]) begin
`ifdef MULDIV_MUL_EN
                        lo_d    = mag2;
                        opnd_d  = mag1;
                        busy_d  = 1'b1;
                        state_d = CALC;
`else
                        result_d = '0;
                        dz_d     = 1'b0;
                        ready_d  = 1'b1;
                        state_d  = DONE;
`endif
                    end else if (bus.opdata2_i == '0) begin
                        result_d = '0;
                        dz_d     = 1'b1;
                        ready_d  = 1'b1;
                        state_d  = DONE;
                    end else begin
                        lo_d    = mag1;
                        opnd_d  = mag2;
                        busy_d  = 1'b1;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (bus.annul_i || !bus.start_i) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    hi_d  = step_hi;
                    lo_d  = step_lo;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        result_d = fin;
                        dz_d     = 1'b0;
                        busy_d   = 1'b0;
                        ready_d  = 1'b1;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                if (!bus.start_i || bus.annul_i) begin
                    ready_d = 1'b0;
                    dz_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            is_mul_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
            dz_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            is_mul_q <= is_mul_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            dz_q     <= dz_d;
            result_q <= result_d;
        end
    end

    assign bus.busy_o   = busy_q;
    assign bus.ready_o  = ready_q;
    assign bus.dz_o     = dz_q;
    assign bus.result_o = result_q;
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit for the EX stage. It replaces the fixed 32-bit divider and adds signed/unsigned multiply, divide-by-zero flagging and a working annul path. EX starts an operation and holds `start_i` high while it stalls the pipeline; the unit returns a double-width {hi, lo} result for the HI/LO path.

## Interface
Parameters:
- `WIDTH`, 32, operand width; must be ≥ 4.
- `CNT_W`, $clog2(WIDTH+1), localparam, iteration counter width.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `start_i`  in  1  request; held high by EX for the whole operation.
- `op_i`  in  2  operation: 00 DIVU, 01 DIV, 10 MULTU, 11 MULT; sampled only with start.
- `opdata1_i`  in  WIDTH  dividend / multiplicand; sampled only with start.
- `opdata2_i`  in  WIDTH  divisor / multiplier; sampled only with start.
- `annul_i`  in  1  abort the current operation (pipeline flush).
- `busy_o`  out  1  high while iterating.
- `ready_o`  out  1  result valid.
- `dz_o`  out  1  divide by zero; qualified by ready_o.
- `result_o`  out  2*WIDTH  divide: {remainder, quotient}; multiply: {hi, lo} product.

## Operation
- All outputs are registered. Reset values: busy_o=0, ready_o=0, dz_o=0, result_o=0, state IDLE.
- States:
  - IDLE: on start_i=1 and annul_i=0, latch op and operand magnitudes (absolute values for signed ops) plus the result-sign bits.
    - Divisor 0 on a divide goes to DONE with result 0 and dz=1.
    - Otherwise go to CALC with cnt=0.
  - CALC: busy_o=1. One radix-2 step per cycle: shift-subtract restoring divide, or shift-add multiply. cnt increments.
    - At cnt=WIDTH-1, apply sign correction, register the result and go to DONE.
    - Abort: annul_i=1 or start_i=0 returns to IDLE next edge; no result, ready_o stays 0.
  - DONE: ready_o=1; result_o and dz_o held stable.
    - start_i=0 or annul_i=1 returns to IDLE, clearing ready_o and dz_o. result_o keeps its last value.
    - A new operation is never accepted directly from DONE.
- Sign rules:
  - Quotient is negative iff operand signs differ. Remainder takes the dividend's sign.
  - Product is negative iff operand signs differ. Negation is two's complement over the full field width.
- Boundary cases:
  - Signed MIN / -1 gives quotient MIN (wrap) and remainder 0, with no flag.
  - MIN magnitude is handled as unsigned 2^(WIDTH-1) internally.
  - Start and annul in the same IDLE cycle: annul wins and the state stays IDLE.
  - Reset mid-operation clears all state asynchronously.

## Timing
- E0 is the edge that samples start in IDLE.
- Normal operation: busy_o is high after E0. ready_o rises after edge E(WIDTH), i.e. WIDTH+1 edges including E0.
- Divide by zero: ready_o is high after E0, and busy_o never rises.
- Annul or start_i drop in CALC: busy_o is low after the next edge.
- Back-to-back operations: at least one IDLE cycle between DONE and the next E0.

## Configuration
- `MULDIV_MUL_EN` defined: MULTU/MULT iterate as described in Operation.
- `MULDIV_MUL_EN` undefined: the multiply datapath is removed. A multiply request goes IDLE→DONE after E0 with result_o=0 and dz_o=0. Divide behaviour is unchanged.

## Structure
- Shared package `muldiv_pkg` holds:
  - op encodings (OP_DIVU, OP_DIV, OP_MULTU, OP_MULT)
  - state enum (IDLE, CALC, DONE)
- Sub-module `muldiv_step`: a combinational single iteration. It takes the partial {hi, lo}, the operand and the op class, and returns the next partial. It is instantiated once in CALC.

## Test plan
- DIVU 100 / 7, WIDTH=32 → after 33 edges: ready_o=1, result_o={0x00000002, 0x0000000E}, dz_o=0. ready_o stays high until start_i drops.
- DIV -7 / 2 → result_o={0xFFFFFFFF, 0xFFFFFFFD}.
- DIV 0x80000000 / 0xFFFFFFFF → result_o={0x00000000, 0x80000000}, dz_o=0.
- DIVU 5 / 0 → ready_o and dz_o high after 1 edge, result_o=0, busy_o never high.
- MULT -3 × 5:
  - with MULDIV_MUL_EN → after 33 edges, result_o={0xFFFFFFFF, 0xFFFFFFF1};
  - without it → ready_o after 1 edge, result_o=0.
- annul_i pulsed at cycle 10 of CALC → busy_o low next edge and ready_o never rises; a following DIVU 9/3 returns {0, 3}. rst asserted mid-CALC → all outputs 0 immediately.
